regfile_write_arbiter: RTL

//  Shares the single register-file write port (write/addr3/data3) between two writeback requesters:
//  req0 = ALU writeback, req1 = memory-load writeback.

---
 rtl/regfile_write_arbiter.sv | 118 +++++++++++
 1 files changed

// File: rtl/regfile_write_arbiter.sv
// Two-requester writeback arbiter for the single register-file write port.
// Each requester owns a one-entry slot; round-robin (or age for same-address) drains to rf_*.
module regfile_write_arbiter #(
  parameter int unsigned WORD_SIZE = 16,
  parameter int unsigned ADDR_W    = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req0_valid,
  output logic                   req0_ready,
  input  logic [ADDR_W-1:0]      req0_addr,
  input  logic [WORD_SIZE-1:0]   req0_data,
  input  logic                   req1_valid,
  output logic                   req1_ready,
  input  logic [ADDR_W-1:0]      req1_addr,
  input  logic [WORD_SIZE-1:0]   req1_data,
  output logic                   rf_write,
  output logic [ADDR_W-1:0]      rf_addr,
  output logic [WORD_SIZE-1:0]   rf_data,
  output logic                   grant_id,
  output logic [2**ADDR_W-1:0]   busy_mask
);

  logic                 slot0_full_q, slot1_full_q;
  logic [ADDR_W-1:0]    slot0_addr_q, slot1_addr_q;
  logic [WORD_SIZE-1:0] slot0_data_q, slot1_data_q;
  logic                 age_q, age_d;      // 0: slot0 older, 1: slot1 older
  logic                 rr_last_q;
  logic                 gnt0, gnt1;
  logic                 fill0, fill1;
  logic                 keep0, keep1;

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (slot0_full_q && slot1_full_q) begin
      // Same destination must retire in fill order so the younger value lands last.
      if (slot0_addr_q == slot1_addr_q) begin
        gnt0 = !age_q;
        gnt1 = age_q;
      end else begin
        gnt0 = rr_last_q;
        gnt1 = !rr_last_q;
      end
    end else begin
      gnt0 = slot0_full_q;
      gnt1 = slot1_full_q;
    end
  end

  assign req0_ready = !reset && (!slot0_full_q || gnt0);
  assign req1_ready = !reset && (!slot1_full_q || gnt1);
  assign fill0      = req0_valid && req0_ready;
  assign fill1      = req1_valid && req1_ready;
  assign keep0      = slot0_full_q && !gnt0;
  assign keep1      = slot1_full_q && !gnt1;

  always_comb begin
    age_d = age_q;
    if (fill0 && fill1) begin
      age_d = 1'b0;
    end else if (fill0) begin
      age_d = keep1;
    end else if (fill1) begin
      age_d = !keep0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      slot0_full_q <= 1'b0;
      slot1_full_q <= 1'b0;
      slot0_addr_q <= '0;
      slot1_addr_q <= '0;
      slot0_data_q <= '0;
      slot1_data_q <= '0;
      age_q        <= 1'b0;
      rr_last_q    <= 1'b1;
      rf_write     <= 1'b0;
      rf_addr      <= '0;
      rf_data      <= '0;
      grant_id     <= 1'b0;
    end else begin
      if (fill0) begin
        slot0_full_q <= 1'b1;
        slot0_addr_q <= req0_addr;
        slot0_data_q <= req0_data;
      end else if (gnt0) begin
        slot0_full_q <= 1'b0;
      end
      if (fill1) begin
        slot1_full_q <= 1'b1;
        slot1_addr_q <= req1_addr;
        slot1_data_q <= req1_data;
      end else if (gnt1) begin
        slot1_full_q <= 1'b0;
      end
      age_q <= age_d;
      if (gnt0 || gnt1) begin
        rf_write  <= 1'b1;
        rf_addr   <= gnt1 ? slot1_addr_q : slot0_addr_q;
        rf_data   <= gnt1 ? slot1_data_q : slot0_data_q;
        grant_id  <= gnt1;
        rr_last_q <= gnt1;
      end else begin
        rf_write <= 1'b0;
      end
    end
  end

  always_comb begin
    busy_mask = '0;
    if (slot0_full_q) busy_mask[slot0_addr_q] = 1'b1;
    if (slot1_full_q) busy_mask[slot1_addr_q] = 1'b1;
    if (rf_write)     busy_mask[rf_addr]      = 1'b1;
  end

endmodule
